// File: rtl/cpu_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_arbiter_pkg
// Shared bus types for the unified memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, REQ, RESP)
//   arb_owner_e : which requester owns the outstanding transaction
//   mem_req_t   : one memory request {addr, we, wdata, wstrb}; used both for
//                 the requester inputs and for the registered bus_* fields
//   fetch_req() : builds the request record for an instruction fetch
// Optional feature macro (used by the picker and the top): MEM_ARB_RR_EN
// ----------------------------------------------------------------------------
package cpu_mem_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              we;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    // A fetch is always a plain read: no write data, no byte enables.
    function automatic mem_req_t fetch_req(input logic [XLEN-1:0] addr);
        mem_req_t r;
        r.addr  = addr;
        r.we    = 1'b0;
        r.wdata = '0;
        r.wstrb = '0;
        return r;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_picker.sv
// ----------------------------------------------------------------------------
// mem_arb_picker
// Combinational winner selection between the fetch and load/store requesters.
// Ports:
//   if_req, mem_req : request lines of the two requesters
//   last_owner      : requester granted most recently (round-robin only)
//   valid           : at least one request is present
//   winner          : requester that wins this cycle
// Macro MEM_ARB_RR_EN: defined -> round-robin on ties (the requester that is
// not last_owner wins); undefined -> fixed priority, MEM over IF.
// ----------------------------------------------------------------------------
module mem_arb_picker
    import cpu_mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       mem_req,
    input  arb_owner_e last_owner,
    output logic       valid,
    output arb_owner_e winner
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority never looks at the history.
    logic w_unused_last_owner;
    assign w_unused_last_owner = (last_owner == OWN_MEM);
`endif

    always_comb begin
        valid  = if_req | mem_req;
        winner = OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req && mem_req) begin
            winner = (last_owner == OWN_IF) ? OWN_MEM : OWN_IF;
        end else if (mem_req) begin
            winner = OWN_MEM;
        end
`else
        if (mem_req) begin
            winner = OWN_MEM;
        end
`endif
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares the single unified memory port between the IF-stage fetch requester
// and the MEM-stage load/store requester, one transaction outstanding at a
// time, sequenced by a three-state FSM (IDLE -> REQ -> RESP -> IDLE).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   if_req/if_addr/if_kill        : fetch request, address, kill of in-flight
//   if_gnt/if_rvalid/if_rdata     : fetch accept pulse, response pulse, data
//   mem_req/addr/we/wdata/wstrb   : load/store request fields
//   mem_gnt/mem_rvalid/mem_rdata  : load/store accept, response/ack, data
//   bus_req + bus_addr/we/wdata/wstrb : registered downstream request
//   bus_ready/bus_rvalid/bus_rdata    : downstream accept, response, data
//   busy                          : FSM not in IDLE
// Handshake: a requester holds req and its fields stable until its gnt, which
// pulses only in IDLE in the cycle the request is latched. Downstream, the
// request is held while bus_req=1 until a cycle with bus_ready=1; exactly one
// bus_rvalid cycle is then expected in RESP and ends the transaction.
// bus_rvalid outside RESP is ignored.
// Macro MEM_ARB_RR_EN: round-robin arbitration (see mem_arb_picker).
// ----------------------------------------------------------------------------
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              mem_req,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              bus_req,
    output logic [XLEN-1:0]   bus_addr,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              busy
);

    arb_state_e r_state;
    arb_owner_e r_owner;
    logic       r_drop;
    mem_req_t   r_bus;

    logic       w_valid;
    arb_owner_e w_winner;
    arb_owner_e w_last_owner;
    mem_req_t   w_mem_in;
    logic       w_grant;
    logic       w_if_kill_owned;

`ifdef MEM_ARB_RR_EN
    arb_owner_e r_last_owner;
    assign w_last_owner = r_last_owner;
`else
    assign w_last_owner = OWN_MEM;
`endif

    assign w_mem_in = '{addr: mem_addr, we: mem_we, wdata: mem_wdata, wstrb: mem_wstrb};

    mem_arb_picker u_picker (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .last_owner (w_last_owner),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    assign w_grant         = (r_state == ARB_IDLE) && w_valid;
    // A kill only matters while a fetch is actually in flight.
    assign w_if_kill_owned = if_kill && (r_owner == OWN_IF) && (r_state != ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_IF;
            r_drop  <= 1'b0;
            r_bus   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_owner <= OWN_MEM;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_bus   <= (w_winner == OWN_MEM) ? w_mem_in : fetch_req(if_addr);
                        r_owner <= w_winner;
                        r_drop  <= 1'b0;
                        r_state <= ARB_REQ;
`ifdef MEM_ARB_RR_EN
                        r_last_owner <= w_winner;
`endif
                    end
                end
                ARB_REQ: begin
                    if (w_if_kill_owned) r_drop <= 1'b1;
                    if (bus_ready) r_state <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (w_if_kill_owned) r_drop <= 1'b1;
                    if (bus_rvalid) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign if_gnt  = w_grant && (w_winner == OWN_IF);
    assign mem_gnt = w_grant && (w_winner == OWN_MEM);

    // The kill term also covers a kill arriving in the same cycle as the data.
    assign if_rvalid  = (r_state == ARB_RESP) && (r_owner == OWN_IF) && bus_rvalid
                        && !r_drop && !if_kill;
    assign mem_rvalid = (r_state == ARB_RESP) && (r_owner == OWN_MEM) && bus_rvalid;
    assign if_rdata   = bus_rdata;
    assign mem_rdata  = bus_rdata;

    assign bus_req   = (r_state == ARB_REQ);
    assign bus_addr  = r_bus.addr;
    assign bus_we    = r_bus.we;
    assign bus_wdata = r_bus.wdata;
    assign bus_wstrb = r_bus.wstrb;
    assign busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_mem_arbiter
// Per-cycle vector table for the arbiter followed by hand-written sequences
// for asynchronous reset and sustained contention.
// ----------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_kill    (if_kill),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .busy       (busy)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {if_gnt, mem_gnt, if_rvalid, mem_rvalid, bus_req, busy}
    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        kill;
        logic        mr;
        logic [31:0] ma;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic [5:0]  flags;
        logic [31:0] ea;
        logic        ewe;
        logic [31:0] ewd;
        logic [3:0]  ews;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ifr, input logic [31:0] ifa, input logic kill,
        input logic mr, input logic [31:0] ma, input logic we,
        input logic [31:0] wd, input logic [3:0] ws,
        input logic rdy, input logic rv, input logic [31:0] rd,
        input logic [5:0] flags, input logic [31:0] ea, input logic ewe,
        input logic [31:0] ewd, input logic [3:0] ews);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.kill = kill;
        v.mr = mr; v.ma = ma; v.we = we; v.wd = wd; v.ws = ws;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.flags = flags; v.ea = ea; v.ewe = ewe; v.ewd = ewd; v.ews = ews;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_idle();
        if_req = 0; if_addr = 0; if_kill = 0;
        mem_req = 0; mem_addr = 0; mem_we = 0; mem_wdata = 0; mem_wstrb = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    task automatic apply(input vec_t v);
        if_req = v.ifr; if_addr = v.ifa; if_kill = v.kill;
        mem_req = v.mr; mem_addr = v.ma; mem_we = v.we; mem_wdata = v.wd; mem_wstrb = v.ws;
        bus_ready = v.rdy; bus_rvalid = v.rv; bus_rdata = v.rd;
    endtask

    function automatic logic [74:0] ctl_obs();
        return {if_gnt, mem_gnt, if_rvalid, mem_rvalid, bus_req, busy,
                bus_we, bus_wstrb, bus_addr, bus_wdata};
    endfunction

    initial begin
        logic [74:0] exp_ctl;
        int          n_g;
        int          last_cyc;
        logic        own_q[$];
        logic        exp_own[4];

        // --- vector table ----------------------------------------------------
        // Single fetch 0x100: gnt c0, ready c1, rvalid c3, idle c4
        vq.push_back(mk(1,32'h100,0, 0,0,0,0,0, 0,0,0,           6'b100000, 32'h0,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,           6'b000011, 32'h100,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,           6'b000001, 32'h100,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,1,32'h13,      6'b001001, 32'h100,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,           6'b000000, 32'h100,0,0,0));
        // Contention: MEM load 0x2000 wins, IF waits until after MEM response
        vq.push_back(mk(1,32'h104,0, 1,32'h2000,0,0,0, 0,0,0,    6'b010000, 32'h100,0,0,0));
        vq.push_back(mk(1,32'h104,0, 0,0,0,0,0, 1,0,0,           6'b000011, 32'h2000,0,0,0));
        vq.push_back(mk(1,32'h104,0, 0,0,0,0,0, 0,0,0,           6'b000001, 32'h2000,0,0,0));
        vq.push_back(mk(1,32'h104,0, 0,0,0,0,0, 0,1,32'hCAFEF00D,6'b000101, 32'h2000,0,0,0));
        vq.push_back(mk(1,32'h104,0, 0,0,0,0,0, 0,0,0,           6'b100000, 32'h2000,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,           6'b000011, 32'h104,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,1,32'h11,      6'b001001, 32'h104,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,           6'b000000, 32'h104,0,0,0));
        // Kill in RESP: fetch 0x200 response swallowed, next fetch normal
        vq.push_back(mk(1,32'h200,0, 0,0,0,0,0, 0,0,0,           6'b100000, 32'h104,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,           6'b000011, 32'h200,0,0,0));
        vq.push_back(mk(0,0,1,       0,0,0,0,0, 0,0,0,           6'b000001, 32'h200,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,1,32'h99,      6'b000001, 32'h200,0,0,0));
        vq.push_back(mk(1,32'h204,0, 0,0,0,0,0, 0,0,0,           6'b100000, 32'h200,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,           6'b000011, 32'h204,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,1,32'h55,      6'b001001, 32'h204,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,           6'b000000, 32'h204,0,0,0));
        // Store 0x3000 with 4 cycles of backpressure; stray rvalid and kill ignored
        vq.push_back(mk(0,0,0, 1,32'h3000,1,32'hDEADBEEF,4'hF, 0,0,0, 6'b010000, 32'h204,0,0,0));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,            6'b000011, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0,            6'b000011, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,1, 0,0,0,0,0, 0,0,0,            6'b000011, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,            6'b000011, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 1,1,32'h12345678, 6'b000011, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,            6'b000001, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0,            6'b000101, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,            6'b000000, 32'h3000,1,32'hDEADBEEF,4'hF));
        // Kill in REQ: fetch 0x300 response swallowed
        vq.push_back(mk(1,32'h300,0, 0,0,0,0,0, 0,0,0,      6'b100000, 32'h3000,1,32'hDEADBEEF,4'hF));
        vq.push_back(mk(0,0,1,       0,0,0,0,0, 0,0,0,      6'b000011, 32'h300,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,      6'b000011, 32'h300,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,1,32'hAA, 6'b000001, 32'h300,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,      6'b000000, 32'h300,0,0,0));
        // Kill in the same cycle as the fetch data
        vq.push_back(mk(1,32'h304,0, 0,0,0,0,0, 0,0,0,      6'b100000, 32'h300,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,      6'b000011, 32'h304,0,0,0));
        vq.push_back(mk(0,0,1,       0,0,0,0,0, 0,1,32'hBB, 6'b000001, 32'h304,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,      6'b000000, 32'h304,0,0,0));
        // Kill in IDLE has no effect on the fetch granted that cycle
        vq.push_back(mk(1,32'h308,1, 0,0,0,0,0, 0,0,0,      6'b100000, 32'h304,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 1,0,0,      6'b000011, 32'h308,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,1,32'h77, 6'b001001, 32'h308,0,0,0));
        vq.push_back(mk(0,0,0,       0,0,0,0,0, 0,0,0,      6'b000000, 32'h308,0,0,0));

        // --- reset -----------------------------------------------------------
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {53'h0, ctl_obs()}, 128'h0);
        check("reset_rdata", {64'h0, if_rdata, mem_rdata}, 128'h0);
        rst = 1'b0;

        // --- table ------------------------------------------------------------
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            apply(vq[i]);
            @(negedge clk);
            exp_ctl = {vq[i].flags, vq[i].ewe, vq[i].ews, vq[i].ea, vq[i].ewd};
            check($sformatf("vec%0d_ctl", i), {53'h0, ctl_obs()}, {53'h0, exp_ctl});
            check($sformatf("vec%0d_rdata", i), {64'h0, if_rdata, mem_rdata},
                  {64'h0, vq[i].rd, vq[i].rd});
        end

        // --- asynchronous reset in the middle of RESP -------------------------
        @(posedge clk);
        #1;
        drive_idle();
        mem_req = 1; mem_addr = 32'h4000;
        @(negedge clk);
        check("arst_gnt", {127'h0, mem_gnt}, 128'h1);
        @(posedge clk);
        #1;
        mem_req = 0; mem_addr = 0; bus_ready = 1;
        @(posedge clk);
        #1;
        bus_ready = 0;
        @(negedge clk);
        check("arst_in_resp", {95'h0, busy, bus_req, bus_addr}, {95'h0, 1'b1, 1'b0, 32'h4000});
        #2;
        rst = 1'b1;
        #1;
        check("arst_async_ctl", {53'h0, ctl_obs()}, 128'h0);
        check("arst_async_rdata", {64'h0, if_rdata, mem_rdata}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_rvalid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("arst_no_resp%0d", k), {125'h0, if_rvalid, mem_rvalid, busy}, 128'h0);
        end

        // --- sustained contention ---------------------------------------------
`ifdef MEM_ARB_RR_EN
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(posedge clk);
        #1;
        drive_idle();
        if_req = 1; if_addr = 32'h500;
        mem_req = 1; mem_addr = 32'h600;
        bus_ready = 1; bus_rvalid = 1;
        n_g = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 40 && n_g < 4; cyc++) begin
            @(negedge clk);
            if (if_gnt || mem_gnt) begin
                check($sformatf("cont_single_gnt%0d", n_g), {126'h0, if_gnt, mem_gnt},
                      {126'h0, ~mem_gnt, mem_gnt});
                if (last_cyc >= 0)
                    check($sformatf("cont_gap%0d", n_g), {127'h0, (cyc - last_cyc) >= 3}, 128'h1);
                own_q.push_back(mem_gnt);
                last_cyc = cyc;
                n_g++;
            end
        end
        check("cont_budget", 128'(n_g), 128'd4);
        for (int k = 0; k < own_q.size() && k < 4; k++)
            check($sformatf("cont_owner%0d", k), {127'h0, own_q[k]}, {127'h0, exp_own[k]});
        @(posedge clk);
        #1;
        if_req = 0; mem_req = 0;
        begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (busy && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check("cont_drain", {127'h0, busy}, 128'h0);
        end
        drive_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
